// File: rtl/ps2_pkg.sv
// Shared PS/2 keypad types: frame FSM states, scan-code constants, key map.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] SC_BREAK = 8'hF0;  // break prefix
  localparam logic [7:0] SC_EXT   = 8'hE0;  // extended-key prefix
  localparam logic [7:0] SC_BAT   = 8'hAA;  // self-test passed
  localparam logic [7:0] SC_ACK   = 8'hFA;  // command acknowledge
  localparam logic [7:0] SC_OVR0  = 8'h00;  // key detection overrun
  localparam logic [7:0] SC_OVR1  = 8'hFF;  // key detection overrun
  localparam logic [7:0] SC_F1    = 8'h05;  // F1: machine reset request

  // Host scan code -> {hit, keypad index}; the 4x4 block of the host
  // keyboard starting at '1' stands in for the Chip-8 hex pad.
  function automatic logic [4:0] key_map(input logic [7:0] code);
    logic [4:0] r;
    r = 5'd0;
    case (code)
      8'h16: r = {1'b1, 4'h1};
      8'h1E: r = {1'b1, 4'h2};
      8'h26: r = {1'b1, 4'h3};
      8'h25: r = {1'b1, 4'hC};
      8'h15: r = {1'b1, 4'h4};
      8'h1D: r = {1'b1, 4'h5};
      8'h24: r = {1'b1, 4'h6};
      8'h2D: r = {1'b1, 4'hD};
      8'h1C: r = {1'b1, 4'h7};
      8'h1B: r = {1'b1, 4'h8};
      8'h23: r = {1'b1, 4'h9};
      8'h2B: r = {1'b1, 4'hE};
      8'h1A: r = {1'b1, 4'hA};
      8'h22: r = {1'b1, 4'h0};
      8'h21: r = {1'b1, 4'hB};
      8'h2A: r = {1'b1, 4'hF};
      default: r = 5'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizes one raw PS/2 line and rejects pulses shorter than FILTER samples.
// Latency: output follows a clean input change 2 + FILTER cycles later.
// Backpressure: none; free-running level output.
module ps2_line_filter #(
  parameter int FILTER = 4
) (
  input  logic clk,
  input  logic res_n,
  input  logic raw_i,
  output logic filt_o
);

  localparam int CW = (FILTER > 2) ? $clog2(FILTER) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          filt_q;
  logic          filt_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Two-flop synchronizer; idle PS/2 lines are high, so reset to 1.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Flip the filtered value only on the FILTER-th consecutive disagreeing sample.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Filter state register.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/ps2_keypad.sv
// PS/2 scan-code set 2 receiver mapping 16 host keys onto the Chip-8 hex keypad.
// Latency: outputs update one cycle after the stop-bit falling edge is seen (fe is FILTER+3 cycles after the raw edge).
// Backpressure: none; events are single-cycle pulses that cannot be stalled.
module ps2_keypad #(
  parameter int          FILTER  = 4,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic        clk,
  input  logic        res_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] keys,
  output logic        key_event,
  output logic [3:0]  key_code,
  output logic        key_pressed,
  output logic        frame_error,
  output logic        reset_req
);
  import ps2_pkg::*;

  logic clk_f;
  logic data_f;

  ps2_line_filter #(.FILTER(FILTER)) u_clk_filt (
    .clk    (clk),
    .res_n  (res_n),
    .raw_i  (ps2_clk),
    .filt_o (clk_f)
  );

  ps2_line_filter #(.FILTER(FILTER)) u_data_filt (
    .clk    (clk),
    .res_n  (res_n),
    .raw_i  (ps2_data),
    .filt_o (data_f)
  );

  // ---------------------------------------------------------------- edge
  logic clk_prev_q;
  logic fe_q;
  logic fe_d;

  assign fe_d = clk_prev_q & ~clk_f;

  // Registered falling-edge strobe of the filtered PS/2 clock.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      clk_prev_q <= 1'b1;
      fe_q       <= 1'b0;
    end else begin
      clk_prev_q <= clk_f;
      fe_q       <= fe_d;
    end
  end

  // ---------------------------------------------------------------- frame FSM
  ps2_state_t  state_q, state_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic [15:0] tmo_q, tmo_d;
  logic        byte_vld_q, byte_vld_d;
  logic        err_q, err_d;

  // Frame state and timeout registers.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q    <= IDLE;
      bitcnt_q   <= 3'd0;
      shift_q    <= 8'd0;
      par_q      <= 1'b0;
      tmo_q      <= 16'd0;
      byte_vld_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
      byte_vld_q <= byte_vld_d;
      err_q      <= err_d;
    end
  end

  // Frame sequencing on fe; the fe cycle itself counts towards the timeout,
  // so an abort lands exactly TIMEOUT cycles after the last fe strobe.
  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    tmo_d      = tmo_q;
    byte_vld_d = 1'b0;
    err_d      = 1'b0;
    if (state_q != IDLE) begin
      tmo_d = tmo_q + 16'd1;
    end
    if (fe_q) begin
      tmo_d = 16'd0;
      case (state_q)
        IDLE: begin
          if (!data_f) begin
            state_d  = DATA;
            bitcnt_d = 3'd0;
          end else begin
            err_d = 1'b1;
          end
        end
        DATA: begin
          shift_d = {data_f, shift_q[7:1]};
          if (bitcnt_q == 3'd7) begin
            state_d = PARITY;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end
        PARITY: begin
          par_d   = data_f;
          state_d = STOP;
        end
        STOP: begin
          if (data_f && (^{shift_q, par_q})) begin
            byte_vld_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if ((state_q != IDLE) && (tmo_q == TIMEOUT - 16'd2)) begin
      state_d = IDLE;
      tmo_d   = 16'd0;
      err_d   = 1'b1;
    end
  end

  // ---------------------------------------------------------------- decode
  logic [4:0]  km;
  logic        brk_q, brk_d;
  logic        ext_q, ext_d;
  logic [15:0] keys_q, keys_d;
  logic        key_event_q, key_event_d;
  logic [3:0]  key_code_q, key_code_d;
  logic        key_pressed_q, key_pressed_d;
  logic        reset_req_q, reset_req_d;

  // shift_q stays stable for the cycle after byte_vld_q, so it is the byte.
  assign km = key_map(shift_q);

  // Prefix tracking and keypad update for each received byte.
  always_comb begin
    brk_d         = brk_q;
    ext_d         = ext_q;
    keys_d        = keys_q;
    key_event_d   = 1'b0;
    key_code_d    = key_code_q;
    key_pressed_d = key_pressed_q;
    reset_req_d   = 1'b0;
    if (err_q) begin
      brk_d = 1'b0;
      ext_d = 1'b0;
    end else if (byte_vld_q) begin
      if (shift_q == SC_BREAK) begin
        brk_d = 1'b1;
      end else if (shift_q == SC_EXT) begin
        ext_d = 1'b1;
      end else begin
        brk_d = 1'b0;
        ext_d = 1'b0;
        if ((shift_q == SC_OVR0) || (shift_q == SC_OVR1)) begin
          keys_d = 16'd0;
        end else if ((shift_q == SC_BAT) || (shift_q == SC_ACK)) begin
          keys_d = keys_q;
        end else if (!ext_q) begin
          if (km[4]) begin
            keys_d[km[3:0]] = ~brk_q;
            key_event_d     = 1'b1;
            key_code_d      = km[3:0];
            key_pressed_d   = ~brk_q;
          end else if ((shift_q == SC_F1) && !brk_q) begin
            reset_req_d = 1'b1;
          end
        end
      end
    end
  end

  // Decoder state and output registers.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      brk_q         <= 1'b0;
      ext_q         <= 1'b0;
      keys_q        <= 16'd0;
      key_event_q   <= 1'b0;
      key_code_q    <= 4'd0;
      key_pressed_q <= 1'b0;
      reset_req_q   <= 1'b0;
    end else begin
      brk_q         <= brk_d;
      ext_q         <= ext_d;
      keys_q        <= keys_d;
      key_event_q   <= key_event_d;
      key_code_q    <= key_code_d;
      key_pressed_q <= key_pressed_d;
      reset_req_q   <= reset_req_d;
    end
  end

  assign keys        = keys_q;
  assign key_event   = key_event_q;
  assign key_code    = key_code_q;
  assign key_pressed = key_pressed_q;
  assign frame_error = err_q;
  assign reset_req   = reset_req_q;

endmodule

// File: tb/tb_ps2_keypad.sv
// Scoreboard bench for ps2_keypad: directed frames plus random byte stream.
// Latency: checks timeout abort timing against the documented fe latency.
// Backpressure: none on the DUT; the monitor pops one expectation per pulse.
module tb_ps2_keypad;

  localparam int          FILTER  = 4;
  localparam logic [15:0] TIMEOUT = 16'd200;
  localparam int          HP      = 20;  // PS/2 half period in system clocks

  localparam int K_KEY = 0;
  localparam int K_ERR = 1;
  localparam int K_RST = 2;

  logic        clk = 1'b0;
  logic        res_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [15:0] keys;
  logic        key_event;
  logic [3:0]  key_code;
  logic        key_pressed;
  logic        frame_error;
  logic        reset_req;

  always #5 clk = ~clk;

  ps2_keypad #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .res_n       (res_n),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .keys        (keys),
    .key_event   (key_event),
    .key_code    (key_code),
    .key_pressed (key_pressed),
    .frame_error (frame_error),
    .reset_req   (reset_req)
  );

  typedef struct {
    int          kind;
    logic [3:0]  code;
    logic        pressed;
    logic [15:0] keys;
  } exp_t;

  exp_t sb[$];
  int   chk_cnt = 0;
  int   pass_cnt = 0;

  // Keypad index -> host scan code.
  logic [7:0] scan [16] = '{8'h22, 8'h16, 8'h1E, 8'h26, 8'h15, 8'h1D, 8'h24, 8'h1C,
                            8'h1B, 8'h23, 8'h1A, 8'h21, 8'h25, 8'h2D, 8'h2B, 8'h2A};
  logic [15:0] m_keys = 16'd0;
  bit          m_brk = 1'b0;
  bit          m_ext = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic push(input int kind, input logic [3:0] code, input logic pressed);
    exp_t e;
    e.kind    = kind;
    e.code    = code;
    e.pressed = pressed;
    e.keys    = m_keys;
    sb.push_back(e);
  endtask

  // Reference model: what one received byte (or a bad frame) should do.
  task automatic model_byte(input logic [7:0] b, input bit good);
    bit hit;
    int idx;
    hit = 1'b0;
    idx = 0;
    if (!good) begin
      push(K_ERR, 4'd0, 1'b0);
      m_brk = 1'b0;
      m_ext = 1'b0;
      return;
    end
    if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else begin
      for (int i = 0; i < 16; i++) if (scan[i] == b) begin hit = 1'b1; idx = i; end
      if (b == 8'h00 || b == 8'hFF) begin
        m_keys = 16'd0;
      end else if (b == 8'hAA || b == 8'hFA) begin
        m_keys = m_keys;
      end else if (!m_ext) begin
        if (hit) begin
          m_keys[idx] = !m_brk;
          push(K_KEY, idx[3:0], !m_brk);
        end else if (b == 8'h05 && !m_brk) begin
          push(K_RST, 4'd0, 1'b0);
        end
      end
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one bit and drop ps2_clk; glen > 0 adds a short low glitch while high.
  task automatic ps2_fall(input logic bitval, input int glen);
    ps2_data = bitval;
    if (glen > 0) begin
      cyc(4);
      ps2_clk = 1'b0;
      cyc(glen);
      ps2_clk = 1'b1;
      cyc(HP - 4 - glen);
    end else begin
      cyc(HP);
    end
    ps2_clk = 1'b0;
  endtask

  task automatic ps2_rise();
    cyc(HP);
    ps2_clk = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input bit good, input bit glitch);
    logic [10:0] bits;
    int g;
    model_byte(b, good);
    bits = {1'b1, (good ? ~(^b) : (^b)), b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      g = 0;
      if (glitch && i == 2) g = 1;
      if (glitch && i == 5) g = FILTER - 1;
      ps2_fall(bits[i], g);
      ps2_rise();
    end
    ps2_data = 1'b1;
    cyc(2 * HP);
  endtask

  // Monitor: every output pulse consumes one expectation.
  task automatic pop_check(input int kind);
    exp_t e;
    if (sb.size() == 0) begin
      chk_cnt++;
      $display("FAIL unexpected_output: kind %0d seen, scoreboard empty", kind);
    end else begin
      e = sb.pop_front();
      check("out_kind", kind, e.kind);
      if (kind == K_KEY && e.kind == K_KEY) begin
        check("key_code", {28'd0, key_code}, {28'd0, e.code});
        check("key_pressed", {31'd0, key_pressed}, {31'd0, e.pressed});
        check("keys_at_event", {16'd0, keys}, {16'd0, e.keys});
      end
    end
  endtask

  logic ev_prev = 1'b0, er_prev = 1'b0, rr_prev = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (res_n) begin
        if (key_event) begin
          check("key_event_width", {31'd0, ev_prev}, 32'd0);
          pop_check(K_KEY);
        end
        if (frame_error) begin
          check("frame_error_width", {31'd0, er_prev}, 32'd0);
          pop_check(K_ERR);
        end
        if (reset_req) begin
          check("reset_req_width", {31'd0, rr_prev}, 32'd0);
          pop_check(K_RST);
        end
      end
      ev_prev = key_event;
      er_prev = frame_error;
      rr_prev = reset_req;
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_keys"}, {16'd0, keys}, 32'd0);
    check({tag, "_key_event"}, {31'd0, key_event}, 32'd0);
    check({tag, "_key_code"}, {28'd0, key_code}, 32'd0);
    check({tag, "_key_pressed"}, {31'd0, key_pressed}, 32'd0);
    check({tag, "_frame_error"}, {31'd0, frame_error}, 32'd0);
    check({tag, "_reset_req"}, {31'd0, reset_req}, 32'd0);
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] part;
    int         c;
    int         r;
    bit         good;

    cyc(3);
    check_outputs_zero("reset");
    res_n = 1'b1;
    cyc(10);

    // Make, then break of key 1.
    send(8'h16, 1'b1, 1'b0);
    check("keys_after_make16", {16'd0, keys}, 32'h0002);
    send(8'hF0, 1'b1, 1'b0);
    send(8'h16, 1'b1, 1'b0);
    check("keys_after_break16", {16'd0, keys}, 32'h0000);

    // Bad parity, then an extended code that must be ignored.
    send(8'h1C, 1'b0, 1'b0);
    check("keys_after_bad_parity", {16'd0, keys}, {16'd0, m_keys});
    send(8'hE0, 1'b1, 1'b0);
    send(8'h1C, 1'b1, 1'b0);
    check("keys_after_ext", {16'd0, keys}, 32'h0000);

    // Frame abandoned after four data bits: abort timing from the last raw fall.
    model_byte(8'h00, 1'b0);
    part = 8'h5A;
    ps2_fall(1'b0, 0);
    for (int i = 0; i < 4; i++) begin
      ps2_rise();
      ps2_fall(part[i], 0);
    end
    c = 0;
    for (int i = 1; i <= 2 * int'(TIMEOUT) + 100; i++) begin
      @(posedge clk);
      #1;
      if (frame_error) begin c = i; break; end
    end
    check("timeout_latency", c, FILTER + 3 + int'(TIMEOUT));
    ps2_rise();
    ps2_data = 1'b1;
    cyc(2 * HP);
    send(8'h2A, 1'b1, 1'b0);
    check("keys_after_timeout_2A", {16'd0, keys}, 32'h8000);

    // Release F, then key 0 with glitches on ps2_clk.
    send(8'hF0, 1'b1, 1'b0);
    send(8'h2A, 1'b1, 1'b0);
    send(8'h22, 1'b1, 1'b1);
    check("keys_after_glitch_22", {16'd0, keys}, 32'h0001);

    // F1 reset request, then overrun clears held keys.
    send(8'h05, 1'b1, 1'b0);
    send(8'h16, 1'b1, 1'b0);
    send(8'h1E, 1'b1, 1'b0);
    check("keys_held_before_overrun", {16'd0, keys}, 32'h0007);
    send(8'h00, 1'b1, 1'b0);
    check("keys_after_overrun", {16'd0, keys}, 32'h0000);

    // Reset asserted mid-frame.
    send(8'h16, 1'b1, 1'b0);
    part = 8'h1D;
    ps2_fall(1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      ps2_rise();
      ps2_fall(part[i], 0);
    end
    cyc(3);
    res_n = 1'b0;
    cyc(2);
    check_outputs_zero("midframe_reset");
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    m_keys = 16'd0;
    m_brk  = 1'b0;
    m_ext  = 1'b0;
    cyc(5);
    res_n = 1'b1;
    cyc(20);
    send(8'h1D, 1'b1, 1'b0);
    check("keys_after_reset_1D", {16'd0, keys}, 32'h0020);

    // Random byte stream.
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      good = 1'b1;
      case (r)
        0, 1, 2, 3: b = scan[$urandom_range(0, 15)];
        4:          b = 8'hF0;
        5:          b = 8'hE0;
        6:          b = 8'h05;
        7: begin
          c = $urandom_range(0, 3);
          b = (c == 0) ? 8'h00 : (c == 1) ? 8'hFF : (c == 2) ? 8'hAA : 8'hFA;
        end
        8:          b = 8'($urandom_range(0, 255));
        default: begin
          b = scan[$urandom_range(0, 15)];
          good = 1'b0;
        end
      endcase
      send(b, good, 1'($urandom_range(0, 1)));
      check("keys_random", {16'd0, keys}, {16'd0, m_keys});
    end

    cyc(50);
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/ps2_keypad.md
# ps2_keypad

Decodes the PS/2 keyboard stream (`ps2_clk`/`ps2_data` from `user_io`) into the 16-key Chip-8 hex keypad state consumed by the `chip8` machine. The block:
- oversamples and filters the PS/2 lines in the system clock domain;
- frames and parity-checks scan-code set 2 bytes;
- tracks make/break prefixes;
- maps 16 host keys onto keypad indices 0x0–0xF.

It also raises a one-cycle reset request on F1, which the top-level reset circuit ORs with its other reset triggers.

## Interface
Parameters:
- `FILTER`, 4: consecutive equal samples needed before a filtered PS/2 line changes (≥2).
- `TIMEOUT`, 16'd50000: system clocks allowed between falling edges inside a frame before the frame is aborted.

Ports:
- `clk` in 1: system clock; all logic on its rising edge.
- `res_n` in 1: reset; asynchronous, active-low.
- `ps2_clk` in 1: raw PS/2 clock, asynchronous.
- `ps2_data` in 1: raw PS/2 data, asynchronous.
- `keys` out 16: keypad state; bit n = 1 while key n is held.
- `key_event` out 1: one-cycle pulse on every mapped make or break.
- `key_code` out 4: keypad index of the last event; held between events.
- `key_pressed` out 1: 1 = make, 0 = break, for the last event; held between events.
- `frame_error` out 1: one-cycle pulse on a start, parity, stop or timeout error.
- `reset_req` out 1: one-cycle pulse on F1 make (0x05).

## Operation
- **Input conditioning.** Both lines pass through a 2-FF synchronizer, then a per-line filter.
  - A filtered line changes only after `FILTER` consecutive samples disagree with its current value.
  - Filtered values reset to 1.
- **Edge detect.** Falling edge of filtered `ps2_clk` → `fe` strobe, one cycle.
- **Frame FSM** (advances only on `fe`):
  - IDLE: data 0 → DATA with bit count = 0. Data 1 → `frame_error`, stay in IDLE.
  - DATA: shift data in LSB first. After the 8th bit → PARITY.
  - PARITY: latch bit. Odd parity over the 8 data bits plus the parity bit is required.
  - STOP: data 1 with good parity → byte valid. Otherwise → `frame_error` and the byte is discarded. Both cases return to IDLE.
- **Timeout.** In any state other than IDLE, a 16-bit counter increments each cycle and clears on `fe`.
  - Reaching `TIMEOUT` → IDLE, `frame_error`, and the `brk`/`ext` flags are cleared.
  - If `fe` and the timeout fall on the same cycle, `fe` wins.
- **Byte decode** (on byte valid):
  - 0xF0 → set `brk`.
  - 0xE0 → set `ext`.
  - 0x00 or 0xFF (keyboard overrun) → `keys` = 0; no `key_event`.
  - 0xAA, 0xFA → ignored.
  - Any other byte: if `ext` = 1, ignore the byte. Else, if the code is mapped, `keys[n]` ← !`brk`, `key_event` pulses, `key_code` = n, `key_pressed` = !`brk`. Else, if the code is 0x05 and `brk` = 0, `reset_req` pulses.
  - `brk` and `ext` clear after every non-prefix byte and after every frame error.
- **Key map** (scan code → index):
  - Row 1: 16→1, 1E→2, 26→3, 25→C.
  - Row 2: 15→4, 1D→5, 24→6, 2D→D.
  - Row 3: 1C→7, 1B→8, 23→9, 2B→E.
  - Row 4: 1A→A, 22→0, 21→B, 2A→F.
- **Repeats.** Typematic repeats re-pulse `key_event` with `key_pressed` = 1; `keys` is unchanged.
- **Reset values.** All outputs are 0. FSM = IDLE, flags = 0, counters = 0. Assertion mid-frame discards the partial byte.

## Timing
- `fe` occurs 2 (sync) + `FILTER` + 1 cycles after a clean raw falling edge.
- Byte valid is registered on the stop-bit `fe`. All effects appear the next cycle: `keys` update, `key_event`, `key_code`/`key_pressed` update, `reset_req`.
- Every pulse output is exactly one cycle wide. At most one event occurs per byte.
- Pulses narrower than `FILTER` cycles on either line never reach the FSM.

## Structure
- Shared package `ps2_pkg`:
  - FSM state enum (IDLE, DATA, PARITY, STOP);
  - prefix constants 0xF0, 0xE0, 0xAA, 0xFA, 0x00, 0xFF, 0x05;
  - the scan-code → index map as a function returning {hit, index}.
- Sub-module `ps2_line_filter` (synchronizer + sample filter), instantiated twice.

## Test plan
- Clean frame 0x16 → `keys` = 16'h0002; `key_event` 1 cycle; `key_code` = 1; `key_pressed` = 1.
- Then F0, 16 → `keys` = 16'h0000; `key_event` with `key_pressed` = 0; no event on the F0 byte itself.
- Frame 0x1C with even parity → `frame_error` pulse; `keys` unchanged. Then E0, 1C → no event; `keys` = 0.
- Stop ps2_clk after 4 data bits → `frame_error` exactly `TIMEOUT` cycles after the last `fe`. A following clean 0x2A frame → `keys` = 16'h8000.
- 1-cycle and (`FILTER`−1)-cycle glitches on ps2_clk during frame 0x22 → decoded correctly; `keys` = 16'h0001.
- 0x05 → `reset_req` pulses once. With keys 1, 2 held, byte 0x00 → `keys` = 0. `res_n` low mid-frame → all outputs 0; the next clean frame decodes.
